// File: rtl/pwm_update_sched_pkg.sv
// Shared types and helpers for the per-channel PWM update scheduler.
package pwm_update_sched_pkg;

    localparam int PWMCOUNT_WIDTH = 16;
    localparam int SKIP_WIDTH     = 4;

    // FAULT shares the low two bits with DRAIN, so the 2-bit state port reads 2'b11 for both.
    typedef logic [2:0] sched_state_t;
    localparam sched_state_t IDLE  = 3'b000;
    localparam sched_state_t ARM   = 3'b001;
    localparam sched_state_t RUN   = 3'b010;
    localparam sched_state_t DRAIN = 3'b011;
    localparam sched_state_t FAULT = 3'b111;

    typedef enum logic [1:0] {
        UPD_ZERO   = 2'd0,
        UPD_PERIOD = 2'd1,
        UPD_BOTH   = 2'd2,
        UPD_IMM    = 2'd3
    } upd_mode_t;

    function automatic logic qual_event(input upd_mode_t mode, input logic zero_ev,
                                        input logic per_ev);
        case (mode)
            UPD_ZERO:   return zero_ev;
            UPD_PERIOD: return per_ev;
            UPD_BOTH:   return zero_ev | per_ev;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/pwm_update_sched_event_det.sv
// Carrier boundary detector: registers the previous carrier and flags entry into zero / top.
module carrier_event_det #(
    parameter int PWMCOUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PWMCOUNT_W-1:0] carrier,
    input  logic [PWMCOUNT_W-1:0] carrier_period,
    output logic                  zero_ev,
    output logic                  per_ev
);

    logic [PWMCOUNT_W-1:0] carrier_prev;

    always_ff @(posedge clk) begin
        if (reset) carrier_prev <= '0;
        else       carrier_prev <= carrier;
    end

    // Edge-style detection so a carrier parked at zero or top yields a single event.
    assign zero_ev = (carrier == '0) && (carrier_prev != '0);
    assign per_ev  = (carrier == carrier_period) && (carrier_prev != carrier_period);

endmodule

// File: rtl/pwm_update_sched.sv
// Per-channel start/stop/fault sequencer and shadow-load scheduler for a PWM compare channel.
// Build option PWM_UPDATE_SKIP_EN: defer each update by update_skip qualifying events.
module pwm_update_sched
    import pwm_update_sched_pkg::*;
#(
    parameter int PWMCOUNT_W = PWMCOUNT_WIDTH,
    parameter int SKIP_W     = SKIP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PWMCOUNT_W-1:0] carrier,
    input  logic [PWMCOUNT_W-1:0] carrier_period,
    input  logic                  sw_enable,
    input  logic                  update_req,
    input  logic [1:0]            update_mode,
    input  logic [SKIP_W-1:0]     update_skip,
    input  logic                  fault,
    input  logic                  fault_clr,
    output logic                  maskevent,
    output logic                  pwm_onoff,
    output logic                  carrier_onoff,
    output logic                  update_pending,
    output logic [1:0]            state
);

    sched_state_t st_q, st_d;
    logic zero_ev, per_ev, qual_ev;
    logic in_upd, keep_upd, want, hit, fire;
    logic pend_d, mask_d, pwm_d, cof_d;

    carrier_event_det #(.PWMCOUNT_W(PWMCOUNT_W)) u_event_det (
        .clk            (clk),
        .reset          (reset),
        .carrier        (carrier),
        .carrier_period (carrier_period),
        .zero_ev        (zero_ev),
        .per_ev         (per_ev)
    );

    assign qual_ev = qual_event(upd_mode_t'(update_mode), zero_ev, per_ev);

    always_comb begin
        st_d = st_q;
        if (fault) begin
            st_d = FAULT;
        end else begin
            case (st_q)
                IDLE:    if (sw_enable) st_d = ARM;
                ARM:     if (zero_ev) st_d = RUN;
                RUN:     if (!sw_enable) st_d = DRAIN;
                DRAIN:   if (sw_enable) st_d = RUN;
                         else if (zero_ev) st_d = IDLE;
                FAULT:   if (fault_clr) st_d = IDLE;
                default: st_d = IDLE;
            endcase
        end
    end

    // Updates are only tracked while the channel is live; any other state drops them.
    assign in_upd   = !fault && (st_q == RUN || st_q == DRAIN);
    assign keep_upd = (st_d == RUN || st_d == DRAIN);
    assign want     = in_upd && (update_pending || update_req);

`ifdef PWM_UPDATE_SKIP_EN
    logic [SKIP_W-1:0] skip_q, skip_d;

    assign hit = (skip_q == update_skip);

    always_comb begin
        skip_d = '0;
        if (pend_d) skip_d = (want && qual_ev) ? skip_q + 1'b1 : skip_q;
    end

    always_ff @(posedge clk) begin
        if (reset) skip_q <= '0;
        else       skip_q <= skip_d;
    end
`else
    logic unused_skip;

    assign hit         = 1'b1;
    assign unused_skip = ^update_skip;
`endif

    assign fire   = want && qual_ev && hit;
    assign pend_d = want && !fire && keep_upd;
    assign mask_d = ((st_q == IDLE) && (st_d == ARM)) || fire;
    assign pwm_d  = (st_d == RUN) || (st_d == DRAIN);
    assign cof_d  = pwm_d || (st_d == ARM);

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q           <= IDLE;
            maskevent      <= 1'b0;
            pwm_onoff      <= 1'b0;
            carrier_onoff  <= 1'b0;
            update_pending <= 1'b0;
        end else begin
            st_q           <= st_d;
            maskevent      <= mask_d;
            pwm_onoff      <= pwm_d;
            carrier_onoff  <= cof_d;
            update_pending <= pend_d;
        end
    end

    assign state = st_q[1:0];

endmodule

// File: tb/tb_pwm_update_sched.sv
// Bench for pwm_update_sched: directed scenarios plus randomized traffic against a phase-level model.
module tb_pwm_update_sched;

    localparam int PW = 16;
    localparam int SW = 4;
`ifdef PWM_UPDATE_SKIP_EN
    localparam int EXP_Z = 3;
`else
    localparam int EXP_Z = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] carrier, carrier_period;
    logic          sw_enable, update_req, fault, fault_clr;
    logic [1:0]    update_mode;
    logic [SW-1:0] update_skip;
    logic          maskevent, pwm_onoff, carrier_onoff, update_pending;
    logic [1:0]    state;

    pwm_update_sched #(.PWMCOUNT_W(PW), .SKIP_W(SW)) dut (
        .clk            (clk),
        .reset          (reset),
        .carrier        (carrier),
        .carrier_period (carrier_period),
        .sw_enable      (sw_enable),
        .update_req     (update_req),
        .update_mode    (update_mode),
        .update_skip    (update_skip),
        .fault          (fault),
        .fault_clr      (fault_clr),
        .maskevent      (maskevent),
        .pwm_onoff      (pwm_onoff),
        .carrier_onoff  (carrier_onoff),
        .update_pending (update_pending),
        .state          (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int top      = 99;
    int cnt      = 0;

    // Reference model: channel phase, pending flag, events seen while pending, last carrier.
    typedef enum int {M_OFF, M_WAIT, M_ON, M_STOP, M_TRIP} phase_t;
    phase_t ph     = M_OFF;
    bit     m_pend = 0;
    bit     m_mask = 0;
    int     m_seen = 0;
    int     m_prev = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_state(input phase_t p);
        case (p)
            M_OFF:   return 0;
            M_WAIT:  return 1;
            M_ON:    return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_step();
        bit z, p, q, hit;
        if (reset) begin
            ph = M_OFF; m_pend = 0; m_seen = 0; m_prev = 0; m_mask = 0;
            return;
        end
        z = (int'(carrier) == 0) && (m_prev != 0);
        p = (int'(carrier) == int'(carrier_period)) && (m_prev != int'(carrier_period));
        m_prev = int'(carrier);
        case (update_mode)
            2'd0:    q = z;
            2'd1:    q = p;
            2'd2:    q = z || p;
            default: q = 1;
        endcase
        m_mask = 0;
        if (fault) begin
            ph = M_TRIP; m_pend = 0; m_seen = 0;
        end else begin
            case (ph)
                M_OFF:  if (sw_enable) begin ph = M_WAIT; m_mask = 1; end
                M_WAIT: if (z) ph = M_ON;
                M_TRIP: if (fault_clr) ph = M_OFF;
                default: begin
                    if ((m_pend || update_req) && q) begin
`ifdef PWM_UPDATE_SKIP_EN
                        hit = (m_seen == int'(update_skip));
`else
                        hit = 1;
`endif
                        if (hit) begin m_mask = 1; m_pend = 0; m_seen = 0; end
                        else begin m_seen++; m_pend = 1; end
                    end else if (update_req) begin
                        m_pend = 1;
                    end
                    if (ph == M_ON) begin
                        if (!sw_enable) ph = M_STOP;
                    end else if (sw_enable) begin
                        ph = M_ON;
                    end else if (z) begin
                        ph = M_OFF; m_pend = 0; m_seen = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("maskevent", maskevent, m_mask);
        check("pwm_onoff", pwm_onoff, (ph == M_ON || ph == M_STOP));
        check("carrier_onoff", carrier_onoff, (ph == M_WAIT || ph == M_ON || ph == M_STOP));
        check("update_pending", update_pending, m_pend);
        check("state", state, exp_state(ph));
        cnt = (cnt >= top) ? 0 : cnt + 1;
        carrier = PW'(cnt);
    endtask

    task automatic wait_carrier(input int v, input string tag);
        int n = 0;
        while (int'(carrier) != v && n < 400) begin tick(); n++; end
        check(tag, carrier, v);
    endtask

    task automatic wait_state(input int v, input string tag);
        int n = 0;
        while (state !== 2'(v) && n < 400) begin tick(); n++; end
        check(tag, state, v);
    endtask

    initial begin
        int masks, consec, zc, zc_at;
        bit last_mask;
        reset = 1; sw_enable = 0; update_req = 0; fault = 0; fault_clr = 0;
        update_mode = 2'd0; update_skip = '0; carrier_period = PW'(99); carrier = '0;
        repeat (3) tick();
        check("reset_pwm", pwm_onoff, 0);
        check("reset_state", state, 0);
        reset = 0;

        // Start at carrier 40
        wait_carrier(40, "reach_40");
        sw_enable = 1;
        tick();
        check("arm_mask", maskevent, 1);
        check("arm_state", state, 1);
        check("arm_cof", carrier_onoff, 1);
        tick();
        check("arm_mask_once", maskevent, 0);
        wait_carrier(0, "reach_0_start");
        check("pwm_before_zero", pwm_onoff, 0);
        tick();
        check("pwm_after_zero", pwm_onoff, 1);
        check("run_state", state, 2);

        // Update at zero
        wait_carrier(30, "reach_30");
        update_req = 1;
        tick();
        update_req = 0;
        check("upd_pending_set", update_pending, 1);
        wait_carrier(0, "reach_0_upd");
        check("upd_no_early_mask", maskevent, 0);
        tick();
        check("upd_mask", maskevent, 1);
        check("upd_pending_clr", update_pending, 0);
        tick();
        check("upd_mask_one", maskevent, 0);

        // Both edges, period 0: zero and top coincide at each wrap
        update_mode = 2'd2; carrier_period = '0; top = 9;
        masks = 0; consec = 0; last_mask = 0;
        update_req = 1;
        repeat (40) begin
            tick();
            if (maskevent) masks++;
            if (maskevent && last_mask) consec++;
            last_mask = maskevent;
        end
        update_req = 0;
        check("both_no_consec", consec, 0);
        check("both_count", masks, 4);
        tick();
        update_mode = 2'd0; carrier_period = PW'(99); top = 99;

        // Stop at carrier 50
        wait_carrier(50, "reach_50");
        sw_enable = 0;
        tick();
        check("drain_state", state, 3);
        check("drain_pwm", pwm_onoff, 1);
        wait_carrier(0, "reach_0_stop");
        check("drain_pwm_hold", pwm_onoff, 1);
        tick();
        check("stop_pwm", pwm_onoff, 0);
        check("stop_cof", carrier_onoff, 0);
        check("stop_state", state, 0);

        // Fault in RUN at carrier 20
        sw_enable = 1;
        wait_state(2, "fault_run");
        wait_carrier(20, "reach_20");
        fault = 1;
        tick();
        check("fault_pwm", pwm_onoff, 0);
        check("fault_state", state, 3);
        fault_clr = 1;
        tick();
        fault_clr = 0;
        check("fault_clr_ignored", state, 3);
        fault = 0;
        tick();
        check("fault_hold", state, 3);
        fault_clr = 1;
        tick();
        fault_clr = 0;
        check("fault_exit", state, 0);

        // Reset mid-RUN
        wait_state(2, "rst_run");
        repeat (5) tick();
        reset = 1;
        tick();
        reset = 0;
        check("rst_pwm", pwm_onoff, 0);
        check("rst_cof", carrier_onoff, 0);
        check("rst_state", state, 0);
        check("rst_mask", maskevent, 0);

        // Skip divider (ignored in the default build)
        wait_state(2, "skip_run");
        update_skip = SW'(2);
        wait_carrier(30, "reach_30_skip");
        update_req = 1;
        tick();
        update_req = 0;
        masks = 0; zc = 0; zc_at = -1;
        repeat (350) begin
            if (int'(carrier) == 0) zc++;
            tick();
            if (maskevent) begin masks++; zc_at = zc; end
        end
        check("skip_masks", masks, 1);
        check("skip_zero_index", zc_at, EXP_Z);
        update_skip = SW'(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                update_mode = 2'($urandom_range(0, 3));
                top = $urandom_range(4, 20);
                carrier_period = ($urandom_range(0, 3) == 0) ? '0 : PW'(top);
            end
            if ($urandom_range(0, 59) == 0) sw_enable = ~sw_enable;
            update_req = ($urandom_range(0, 7) == 0);
            if (!fault) fault = ($urandom_range(0, 299) == 0);
            else        fault = ($urandom_range(0, 9) != 0);
            fault_clr = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 799) == 0);
            tick();
        end
        reset = 0; update_req = 0; fault = 0; fault_clr = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
